ordered_list_reader: RTL

- Drains a snapshot of the k-nearest ordered list (the flattened comp/bag buses produced by the list units) as a valid/ready stream, smallest comp first.
- Sits between the KNN distance/insert datapath and the classification/host-readout logic.
- Captures the whole list in one cycle so the list can be reset or refilled while the readout proceeds.

---
 rtl/ordered_list_reader_pkg.sv | 17 +
 rtl/ordered_list_reader_vote_tally.sv | 73 +++++++
 rtl/ordered_list_reader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ordered_list_reader_pkg.sv
// Shared definitions for the ordered-list reader: FSM state encoding and
// the numRead clamp rule.
package ordered_list_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_STREAM,
        ST_FIN
    } state_t;

    // A request of 0, or one larger than the list, means "the whole list".
    function automatic int clamp_count(input int n, input int list_size);
        return ((n == 0) || (n > list_size)) ? list_size : n;
    endfunction

endpackage

// File: rtl/ordered_list_reader_vote_tally.sv
// Per-label vote counters with first-seen index tracking and a nearest-wins
// argmax. Only built when KNN_READER_VOTE_EN is defined.
`ifdef KNN_READER_VOTE_EN
module knn_vote_tally #(
    parameter int LABEL_W = 4,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_inc,
    input  logic [LABEL_W-1:0] i_label,
    input  logic [CNT_W-1:0]   i_idx,
    input  logic               i_fin,
    output logic [LABEL_W-1:0] o_label
);
    localparam int NUM_LBL = 1 << LABEL_W;

    logic [CNT_W-1:0]   r_cnt   [NUM_LBL];
    logic [CNT_W-1:0]   r_first [NUM_LBL];
    logic               r_seen  [NUM_LBL];
    logic [LABEL_W-1:0] r_label;
    logic [LABEL_W-1:0] w_best;
    logic [CNT_W-1:0]   w_best_cnt;
    logic [CNT_W-1:0]   w_best_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < NUM_LBL; l++) begin
                r_cnt[l]   <= '0;
                r_first[l] <= '0;
                r_seen[l]  <= 1'b0;
            end
            r_label <= '0;
        end else begin
            if (i_clear) begin
                for (int l = 0; l < NUM_LBL; l++) begin
                    r_cnt[l]   <= '0;
                    r_first[l] <= '0;
                    r_seen[l]  <= 1'b0;
                end
            end else if (i_inc) begin
                r_cnt[i_label] <= r_cnt[i_label] + CNT_W'(1);
                if (!r_seen[i_label]) begin
                    r_seen[i_label]  <= 1'b1;
                    r_first[i_label] <= i_idx;
                end
            end
            if (i_fin) begin
                r_label <= w_best;
            end
        end
    end

    // Equal counts resolve to the label first seen closest to the query.
    always_comb begin
        w_best       = '0;
        w_best_cnt   = '0;
        w_best_first = '1;
        for (int l = 0; l < NUM_LBL; l++) begin
            if (r_seen[l] && ((r_cnt[l] > w_best_cnt) ||
                              ((r_cnt[l] == w_best_cnt) && (r_first[l] < w_best_first)))) begin
                w_best       = LABEL_W'(l);
                w_best_cnt   = r_cnt[l];
                w_best_first = r_first[l];
            end
        end
    end

    assign o_label = i_fin ? w_best : r_label;

endmodule
`endif

// File: rtl/ordered_list_reader.sv
// Snapshots the k-nearest list and streams it smallest-first over valid/ready.
// Optional majority vote on bag labels: define KNN_READER_VOTE_EN.
module ordered_list_reader
    import ordered_list_reader_pkg::*;
#(
    parameter int COMP_W    = 32,
    parameter int BAG_W     = 32,
    parameter int LIST_SIZE = 8,
    parameter int CNT_W     = 4
`ifdef KNN_READER_VOTE_EN
    ,
    parameter int LABEL_W   = 4
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_W-1:0]            numRead,
    input  logic [COMP_W*LIST_SIZE-1:0] compIn,
    input  logic [BAG_W*LIST_SIZE-1:0]  bagIn,
    output logic                        busy,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [COMP_W-1:0]           outComp,
    output logic [BAG_W-1:0]            outBag,
    output logic [CNT_W-1:0]            outIdx,
    output logic                        outLast,
    output logic                        done,
    output logic [CNT_W-1:0]            readCount
`ifdef KNN_READER_VOTE_EN
    ,
    output logic [LABEL_W-1:0]          voteLabel,
    output logic                        voteValid
`endif
);
    localparam int IDX_W = (LIST_SIZE > 1) ? $clog2(LIST_SIZE) : 1;
    localparam logic [COMP_W-1:0] EMPTY_COMP = '1;
    localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(LIST_SIZE - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COMP_W-1:0]  r_comp [LIST_SIZE];
    logic [BAG_W-1:0]   r_bag  [LIST_SIZE];
    logic [CNT_W-1:0]   r_limit;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_read_count;
    logic [IDX_W-1:0]   w_rd_sel;
    logic [IDX_W-1:0]   w_nx_sel;
    logic               w_start_acc;
    logic               w_fire;
    logic               w_last;
    logic               w_next_empty;

    assign w_start_acc  = (r_state == ST_IDLE) && start;
    assign w_rd_sel     = r_idx[IDX_W-1:0];
    assign w_nx_sel     = (r_idx == LAST_IDX) ? w_rd_sel : (w_rd_sel + IDX_W'(1));
    assign w_next_empty = (r_comp[w_nx_sel] == EMPTY_COMP);
    assign w_last       = (r_idx == (r_limit - CNT_W'(1))) || (r_idx == LAST_IDX) || w_next_empty;
    assign w_fire       = (r_state == ST_STREAM) && outReady;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_SCAN;
            ST_SCAN:   w_state_nxt = (r_comp[0] == EMPTY_COMP) ? ST_FIN : ST_STREAM;
            ST_STREAM: if (w_fire && w_last) w_state_nxt = ST_FIN;
            ST_FIN:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The snapshot decouples the stream from the live list, which may be
    // cleared or refilled as soon as the capture cycle has passed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LIST_SIZE; i++) begin
                r_comp[i] <= '0;
                r_bag[i]  <= '0;
            end
            r_limit      <= '0;
            r_idx        <= '0;
            r_read_count <= '0;
        end else begin
            if (w_start_acc) begin
                for (int i = 0; i < LIST_SIZE; i++) begin
                    r_comp[i] <= compIn[i*COMP_W +: COMP_W];
                    r_bag[i]  <= bagIn[i*BAG_W +: BAG_W];
                end
                r_limit <= CNT_W'(clamp_count(int'(numRead), LIST_SIZE));
                r_idx   <= '0;
            end else if (w_fire && !w_last) begin
                r_idx <= r_idx + CNT_W'(1);
            end

            if ((r_state == ST_SCAN) && (r_comp[0] == EMPTY_COMP)) begin
                r_read_count <= '0;
            end else if (w_fire && w_last) begin
                r_read_count <= r_idx + CNT_W'(1);
            end
        end
    end

    assign busy      = (r_state == ST_SCAN) || (r_state == ST_STREAM);
    assign outValid  = (r_state == ST_STREAM);
    assign outComp   = outValid ? r_comp[w_rd_sel] : '0;
    assign outBag    = outValid ? r_bag[w_rd_sel] : '0;
    assign outIdx    = outValid ? r_idx : '0;
    assign outLast   = outValid && w_last;
    assign done      = (r_state == ST_FIN);
    assign readCount = r_read_count;

`ifdef KNN_READER_VOTE_EN
    knn_vote_tally #(
        .LABEL_W (LABEL_W),
        .CNT_W   (CNT_W)
    ) u_vote_tally (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start_acc),
        .i_inc   (w_fire),
        .i_label (r_bag[w_rd_sel][LABEL_W-1:0]),
        .i_idx   (r_idx),
        .i_fin   (done),
        .o_label (voteLabel)
    );

    assign voteValid = done && (r_read_count != '0);
`endif

endmodule
